// File: rtl/rr_arbiter_timeslice_param_if.sv
// Request/grant bundle between N masters and the time-slice arbiter.
interface rr_arbiter_timeslice_param_if #(
  parameter int N       = 4,
  parameter int SLICE_W = 4,
  parameter int ID_W    = $clog2(N)
);
  logic [N-1:0]       req;
  logic [SLICE_W-1:0] slice_len;
  logic [N-1:0]       gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic [SLICE_W-1:0] slice_rem;

  modport master (
    output req, slice_len,
    input  gnt, gnt_valid, gnt_id, slice_rem
  );

  modport slave (
    input  req, slice_len,
    output gnt, gnt_valid, gnt_id, slice_rem
  );
endinterface

// File: rtl/rr_arbiter_timeslice_param.sv
// N-way round-robin arbiter granting for programmable time slices; 1-cycle req->gnt latency,
// fully registered outputs, optional early release when the holder drops its request.
module rr_arbiter_timeslice_param #(
  parameter int N         = 4,
  parameter int SLICE_W   = 4,
  parameter int EARLY_REL = 1,
  parameter int ID_W      = $clog2(N)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  rr_arbiter_timeslice_param_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic [SLICE_W-1:0] slice_rem_q, slice_rem_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic               gnt_valid_q;

  logic               any_req;
  logic               found;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    pick;
  logic [SLICE_W-1:0] slice_load;
  logic               end_slice;

  // Search starts just after the last holder, so the holder itself is considered last.
  always_comb begin
    any_req = |bus.req;
    found   = 1'b0;
    cand    = last_q;
    pick    = last_q;
    for (int i = 1; i <= N; i++) begin
      cand = ID_W'((int'(last_q) + i) % N);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign slice_load = (bus.slice_len == '0) ? '0 : bus.slice_len - SLICE_W'(1);
  assign end_slice  = (slice_rem_q == '0) || ((EARLY_REL != 0) && !bus.req[gnt_id_q]);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_id_d    = gnt_id_q;
    slice_rem_d = slice_rem_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_id_d    = pick;
          last_d      = pick;
          slice_rem_d = slice_load;
        end
      end
      GRANT: begin
        if (end_slice) begin
          if (any_req) begin
            gnt_id_d    = pick;
            last_d      = pick;
            slice_rem_d = slice_load;
          end else begin
            state_d     = IDLE;
            slice_rem_d = '0;
          end
        end else begin
          slice_rem_d = slice_rem_q - SLICE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt_d = (state_d == GRANT) ? (N'(1) << gnt_id_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= ID_W'(N - 1);
      gnt_id_q    <= '0;
      slice_rem_q <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_id_q    <= gnt_id_d;
      slice_rem_q <= slice_rem_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= (state_d == GRANT);
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.slice_rem = slice_rem_q;

endmodule
